// File: rtl/tx_frame_store_fwd.sv
// tx_frame_store_fwd: TX store-and-forward frame buffer between the engine and the MAC.
// Beats are written speculatively into a circular FIFO and become readable only once
// the endframe beat proves the frame matches its declared size. Malformed frames are
// rolled back and reported with a one-cycle err_frame_drop pulse.
// Optional build macro: TX_FRAME_STATS_EN adds stat_frames_tx / stat_frames_drop counters.
module tx_frame_store_fwd #(
  parameter int DATA_W     = 512,
  parameter int PADBYTES_W = 6,
  parameter int MTU_SIZE_W = 16,
  parameter int LOG2_ELS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_val,
  input  logic [DATA_W-1:0]     src_data,
  input  logic                  src_startframe,
  input  logic [MTU_SIZE_W-1:0] src_frame_size,
  input  logic                  src_endframe,
  input  logic [PADBYTES_W-1:0] src_padbytes,
  output logic                  src_rdy,
  output logic                  dst_val,
  output logic [DATA_W-1:0]     dst_data,
  output logic                  dst_last,
  output logic [PADBYTES_W-1:0] dst_padbytes,
  input  logic                  dst_rdy,
  output logic                  err_frame_drop
`ifdef TX_FRAME_STATS_EN
  ,
  output logic [31:0]           stat_frames_tx,
  output logic [31:0]           stat_frames_drop
`endif
);

  localparam int BPB = DATA_W / 8;
  localparam int D   = 1 << LOG2_ELS;
  localparam int PW  = LOG2_ELS + 1;          // pointer width incl. wrap bit
  localparam int EW  = MTU_SIZE_W + 1;        // exp_beats width
  localparam int NW  = EW + PADBYTES_W;       // exp_beats*BPB width
  localparam int MW  = DATA_W + 1 + PADBYTES_W;

  localparam logic [PW-1:0] DEPTH = PW'(D);
  localparam logic [PW-1:0] ONE   = PW'(1);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_BODY = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  logic [1:0]            state, state_n;
  logic [PW-1:0]         wr_ptr, wr_n, commit_ptr, cm_n, rd_ptr, rd_n;
  logic [PW-1:0]         cnt_q, cnt_n, cnt_inc, occ_n;
  logic [EW-1:0]         exp_q, exp_n, s_exp;
  logic [MTU_SIZE_W-1:0] size_q, size_n;
  logic [NW-1:0]         s_need, q_need, pad_ext;
  logic                  s_drop, accept, err_n, we, pop, load, src_rdy_n;
  logic [LOG2_ELS-1:0]   waddr;
  logic [MW-1:0]         wentry, rentry;
  logic [MW-1:0]         mem [D];

  assign accept  = src_val & src_rdy;
  assign cnt_inc = cnt_q + ONE;
  assign pad_ext = NW'(src_padbytes);

  // size-derived values for a startframe beat and for the latched frame
  assign s_exp  = ({1'b0, src_frame_size} + EW'(BPB - 1)) >> PADBYTES_W;
  assign s_need = {s_exp, {PADBYTES_W{1'b0}}} - NW'(src_frame_size);
  assign q_need = {exp_q, {PADBYTES_W{1'b0}}} - NW'(size_q);
  assign s_drop = (src_frame_size == '0) || (s_exp > EW'(D));

  // a new frame always starts at commit_ptr, so a restart overwrites the rolled-back beats
  assign waddr  = src_startframe ? commit_ptr[LOG2_ELS-1:0] : wr_ptr[LOG2_ELS-1:0];
  assign wentry = {src_data, src_endframe, src_endframe ? src_padbytes : {PADBYTES_W{1'b0}}};

  // write-side FSM: speculative write, commit on verified endframe, rollback otherwise
  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    cm_n    = commit_ptr;
    cnt_n   = cnt_q;
    exp_n   = exp_q;
    size_n  = size_q;
    err_n   = 1'b0;
    we      = 1'b0;
    if (accept) begin
      case (state)
        WR_IDLE, WR_BODY: begin
          if (src_startframe) begin
            if (state == WR_BODY) err_n = 1'b1;   // previous frame never ended
            wr_n   = commit_ptr;
            exp_n  = s_exp;
            size_n = src_frame_size;
            if (s_drop) begin
              if (src_endframe) err_n = 1'b1;
              state_n = src_endframe ? WR_IDLE : WR_DROP;
            end else if (src_endframe) begin
              state_n = WR_IDLE;
              if (s_exp == EW'(1) && pad_ext == s_need) begin
                we   = 1'b1;
                cm_n = commit_ptr + ONE;
                wr_n = commit_ptr + ONE;
              end else begin
                err_n = 1'b1;
              end
            end else begin
              we      = 1'b1;
              wr_n    = commit_ptr + ONE;
              cnt_n   = ONE;
              state_n = WR_BODY;
            end
          end else if (state == WR_IDLE) begin
            err_n = 1'b1;                         // stray beat outside a frame
          end else if (src_endframe) begin
            state_n = WR_IDLE;
            if (EW'(cnt_inc) == exp_q && pad_ext == q_need) begin
              we   = 1'b1;
              cm_n = wr_ptr + ONE;
              wr_n = wr_ptr + ONE;
            end else begin
              wr_n  = commit_ptr;
              err_n = 1'b1;
            end
          end else if (EW'(cnt_q) == exp_q) begin
            // already longer than declared: stop filling the FIFO, report at endframe
            wr_n    = commit_ptr;
            state_n = WR_DROP;
          end else begin
            we    = 1'b1;
            wr_n  = wr_ptr + ONE;
            cnt_n = cnt_inc;
          end
        end
        WR_DROP: begin
          if (src_endframe) begin
            state_n = WR_IDLE;
            err_n   = 1'b1;
          end
        end
        default: state_n = WR_IDLE;
      endcase
    end
  end

  // read side: the output stage always mirrors mem[rd_ptr]; rd_ptr advances on transfer
  assign pop    = dst_val & dst_rdy;
  assign rd_n   = rd_ptr + PW'(pop);
  assign load   = (~dst_val | dst_rdy) & (rd_n != commit_ptr);
  assign rentry = mem[rd_n[LOG2_ELS-1:0]];

  // src_rdy is registered from next-state pointers, so it is exact every cycle
  assign occ_n     = wr_n - rd_n;
  assign src_rdy_n = (state_n == WR_DROP) || (occ_n != DEPTH);

  // write FSM and pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WR_IDLE;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      rd_ptr         <= '0;
      cnt_q          <= '0;
      exp_q          <= '0;
      size_q         <= '0;
      err_frame_drop <= 1'b0;
      src_rdy        <= 1'b0;
    end else begin
      state          <= state_n;
      wr_ptr         <= wr_n;
      commit_ptr     <= cm_n;
      rd_ptr         <= rd_n;
      cnt_q          <= cnt_n;
      exp_q          <= exp_n;
      size_q         <= size_n;
      err_frame_drop <= err_n;
      src_rdy        <= src_rdy_n;
    end
  end

  // frame storage, no reset needed: pointers define what is valid
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wentry;
  end

  // registered MAC output stage, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_val      <= 1'b0;
      dst_data     <= '0;
      dst_last     <= 1'b0;
      dst_padbytes <= '0;
    end else if (load) begin
      dst_val                              <= 1'b1;
      {dst_data, dst_last, dst_padbytes}   <= rentry;
    end else if (pop) begin
      dst_val <= 1'b0;
    end
  end

`ifdef TX_FRAME_STATS_EN
  // frame counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_tx   <= '0;
      stat_frames_drop <= '0;
    end else begin
      if (pop && dst_last) stat_frames_tx   <= stat_frames_tx + 32'd1;
      if (err_frame_drop)  stat_frames_drop <= stat_frames_drop + 32'd1;
    end
  end
`endif

endmodule
